// File: rtl/noc_pkg.sv
// Shared NOC definitions: route-tag sizing, address helpers, endpoint state and request layout.
package noc_pkg;

    localparam int NOC_BIT_WIDTH     = 512;
    localparam int NOC_ADDR_WIDTH    = 32;
    localparam int NOC_RADIX         = 2;
    localparam int NOC_NETWORK_DEPTH = 1;

    // Route tag width: one digit of log2(radix) bits per switch level.
    function automatic int route_w(input int radix, input int depth);
        return $clog2(radix) * depth;
    endfunction

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb(input int bit_width);
        return $clog2(bit_width / 8);
    endfunction

    localparam int NOC_ROUTE_W  = route_w(NOC_RADIX, NOC_NETWORK_DEPTH);
    localparam int NOC_ADDR_LSB = addr_lsb(NOC_BIT_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } endpoint_state_t;

    // Default-configuration request as seen on the switch side.
    typedef struct packed {
        logic                      we;
        logic [NOC_BIT_WIDTH-1:0]  data;
        logic [NOC_ADDR_WIDTH-1:0] addr;
        logic [NOC_ROUTE_W-1:0]    route;
    } noc_req_t;

endpackage

// File: rtl/noc_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers and registered full/empty flags.
module noc_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [PTR_W:0]   w_wr_ptr_nxt;
    logic [PTR_W:0]   w_rd_ptr_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    // Next pointer values; a full FIFO ignores pushes, an empty one ignores pops.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_push_ok) begin
            w_wr_ptr_nxt = r_wr_ptr + (PTR_W+1)'(1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_pop_ok) begin
            w_rd_ptr_nxt = r_rd_ptr + (PTR_W+1)'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
    end

    // Pointers and flags; flags are computed from next pointers so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= (w_wr_ptr_nxt[PTR_W] != w_rd_ptr_nxt[PTR_W]) &&
                        (w_wr_ptr_nxt[PTR_W-1:0] == w_rd_ptr_nxt[PTR_W-1:0]);
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
        end
    end

    // Entry storage; contents need no reset because the flags gate every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/noc_memory_endpoint.sv
// Memory-side NOC responder: queues C2M requests, services them in order against
// an on-chip array with fixed latency, and returns single-cycle M2C responses.
module noc_memory_endpoint
    import noc_pkg::*;
#(
    parameter int BIT_WIDTH     = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int RADIX         = 2,
    parameter int NETWORK_DEPTH = 1,
    parameter int MEM_DEPTH     = 256,
    parameter int MEM_LATENCY   = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en_C2M_IN,
    input  logic                                          We_C2M_IN,
    input  logic [BIT_WIDTH-1:0]                          Data_C2M_IN,
    input  logic [ADDR_WIDTH-1:0]                         Addr_C2M_IN,
    input  logic [route_w(RADIX, NETWORK_DEPTH)-1:0]      Route_C2M_IN,
    output logic                                          ready_C2M_OUT,
    output logic                                          en_M2C_OUT,
    output logic [BIT_WIDTH-1:0]                          Data_M2C_OUT,
    output logic [route_w(RADIX, NETWORK_DEPTH):0]        AccessComplete_M2C_OUT
);

    localparam int ROUTE_W = route_w(RADIX, NETWORK_DEPTH);
    localparam int A_LSB   = addr_lsb(BIT_WIDTH);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int REQ_W   = 1 + BIT_WIDTH + ADDR_WIDTH + ROUTE_W;
    localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef struct packed {
        logic                  we;
        logic [BIT_WIDTH-1:0]  data;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROUTE_W-1:0]    route;
    } ep_req_t;

    endpoint_state_t      r_state;
    endpoint_state_t      w_state_nxt;
    ep_req_t              w_fifo_din;
    logic [REQ_W-1:0]     w_fifo_dout;
    ep_req_t              r_req;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_cnt_dec;
    logic                 w_do_access;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     w_idx;
    logic [BIT_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                 r_resp_en;
    logic [BIT_WIDTH-1:0] r_resp_data;
    logic [ROUTE_W:0]     r_resp_ac;
    logic                 w_unused_addr;

    assign w_fifo_din    = {We_C2M_IN, Data_C2M_IN, Addr_C2M_IN, Route_C2M_IN};
    assign w_push        = en_C2M_IN && !w_fifo_full;
    assign ready_C2M_OUT = !w_fifo_full;

    noc_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_fifo_din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Word index ignores byte-offset bits and wraps on the upper address bits.
    assign w_idx         = r_req.addr[A_LSB +: IDX_W];
    assign w_unused_addr = ^r_req.addr;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESPOND;
                end else begin
                    w_state_nxt = ACCESS;
                end
            end
            RESPOND: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM control outputs: pop, latency countdown and the access strobe.
    always_comb begin
        w_pop       = 1'b0;
        w_cnt_dec   = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = !w_fifo_empty;
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_do_access = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RESPOND: begin
                w_pop = 1'b0;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Working register holds the request being serviced; counter times the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_req <= ep_req_t'(w_fifo_dout);
            r_cnt <= CNT_W'(MEM_LATENCY - 1);
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_do_access && r_req.we) begin
            r_mem[w_idx] <= r_req.data;
        end
    end

    // Response registers load at the access edge, so they are valid only during RESPOND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_en   <= 1'b0;
            r_resp_data <= '0;
            r_resp_ac   <= '0;
        end else if (w_do_access) begin
            r_resp_en   <= 1'b1;
            r_resp_data <= r_req.we ? '0 : r_mem[w_idx];
            r_resp_ac   <= {r_req.route, 1'b1};
        end else begin
            r_resp_en   <= 1'b0;
            r_resp_data <= '0;
            r_resp_ac   <= '0;
        end
    end

    assign en_M2C_OUT             = r_resp_en;
    assign Data_M2C_OUT           = r_resp_data;
    assign AccessComplete_M2C_OUT = r_resp_ac;

endmodule

// File: tb/tb_noc_memory_endpoint.sv
// Self-checking bench for noc_memory_endpoint: directed scenarios plus a randomized
// phase, all checked against a transaction-level model (ordered queue, sparse memory,
// arithmetic latency/occupancy rules).
module tb_noc_memory_endpoint;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, we;
    logic [511:0] data;
    logic [31:0]  addr;
    logic [0:0]   route;
    logic         ready, en_o;
    logic [511:0] data_o;
    logic [1:0]   ac_o;

    logic         en2, we2;
    logic [511:0] data2;
    logic [31:0]  addr2;
    logic [3:0]   route2;
    logic         ready2, en_o2;
    logic [511:0] data_o2;
    logic [4:0]   ac_o2;

    always #5 clk = ~clk;

    noc_memory_endpoint dut (
        .clk(clk), .rst(rst), .en_C2M_IN(en), .We_C2M_IN(we), .Data_C2M_IN(data),
        .Addr_C2M_IN(addr), .Route_C2M_IN(route), .ready_C2M_OUT(ready),
        .en_M2C_OUT(en_o), .Data_M2C_OUT(data_o), .AccessComplete_M2C_OUT(ac_o)
    );

    noc_memory_endpoint #(.RADIX(4), .NETWORK_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .en_C2M_IN(en2), .We_C2M_IN(we2), .Data_C2M_IN(data2),
        .Addr_C2M_IN(addr2), .Route_C2M_IN(route2), .ready_C2M_OUT(ready2),
        .en_M2C_OUT(en_o2), .Data_M2C_OUT(data_o2), .AccessComplete_M2C_OUT(ac_o2)
    );

    typedef struct {
        bit           we;
        logic [511:0] data;
        logic [31:0]  addr;
        logic [0:0]   route;
        int           exp_cyc;
    } req_t;

    req_t         pend[$];
    int           pop_cyc[$];
    logic [511:0] mem_m [int];
    int           cyc;
    int           last_exp;
    int           n_vec;
    int           n_err;
    bit           wr_set [8];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 6) & 32'd255);
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check ready against model occupancy, accept, then check outputs.
    task automatic step(output bit acc);
        req_t r;
        int   resp_idx;
        while (pop_cyc.size() > 0 && pop_cyc[0] < cyc) void'(pop_cyc.pop_front());
        chk("ready", ready, (pop_cyc.size() < 4));
        acc = en && (pop_cyc.size() < 4);
        if (acc) begin
            r.we = we; r.data = data; r.addr = addr; r.route = route;
            r.exp_cyc = (cyc + 4 > last_exp + 4) ? cyc + 4 : last_exp + 4;
            last_exp = r.exp_cyc;
            pend.push_back(r);
            pop_cyc.push_back(r.exp_cyc - 3);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].exp_cyc == cyc) begin
            r = pend.pop_front();
            resp_idx = idx_of(r.addr);
            chk("resp_en", en_o, 1);
            chk("resp_ac", ac_o, {r.route, 1'b1});
            if (r.we) begin
                chk("resp_wdata", data_o, 0);
                mem_m[resp_idx] = r.data;
            end else begin
                chk("resp_rdata", data_o, mem_m[resp_idx]);
            end
        end else begin
            chk("quiet", {en_o, data_o, ac_o}, 0);
        end
    endtask

    task automatic send(input bit w, input logic [31:0] a, input logic [511:0] d, input logic r);
        bit acc;
        int n;
        en = 1'b1; we = w; addr = a; data = d; route = r;
        acc = 1'b0; n = 0;
        while (!acc && n < 40) begin
            step(acc);
            n++;
        end
        chk("accept_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        en = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic do_reset();
        en = 1'b0; en2 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_outputs", {en_o, data_o, ac_o}, 0);
        chk("rst_ready", ready, 1);
        pend.delete();
        pop_cyc.delete();
        last_exp = -100;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Route-tag check on the RADIX=4, NETWORK_DEPTH=2 instance.
    task automatic route_test(input bit w, input logic [3:0] rt, input logic [511:0] d,
                              input logic [511:0] exp_data);
        bit acc;
        int t0;
        bit seen;
        en2 = 1'b1; we2 = w; addr2 = 32'h0000_0100; route2 = rt; data2 = d;
        t0 = cyc;
        chk("ready2", ready2, 1);
        step(acc);
        en2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (en_o2) begin
                seen = 1'b1;
                chk("r2_latency", cyc - t0, 4);
                chk("r2_ac", ac_o2, {rt, 1'b1});
                chk("r2_data", data_o2, exp_data);
            end else begin
                step(acc);
            end
        end
        chk("r2_timeout", seen, 1);
        idle(2);
    endtask

    initial begin
        logic [511:0] d1, d2, dr;
        n_vec = 0; n_err = 0; cyc = 0; last_exp = -100;
        en = 1'b0; we = 1'b0; data = '0; addr = '0; route = '0;
        en2 = 1'b0; we2 = 1'b0; data2 = '0; addr2 = '0; route2 = '0;
        for (int i = 0; i < 8; i++) wr_set[i] = 1'b0;

        do_reset();

        // Write then read back, isolated.
        send(1'b1, 32'h0000_0040, {64{8'hAA}}, 1'b1);
        idle(6);
        send(1'b0, 32'h0000_0040, '0, 1'b0);
        idle(6);

        // Six back-to-back reads exercise the full FIFO and backpressure.
        for (int i = 0; i < 6; i++) send(1'b0, 32'h0000_0040, '0, 1'(i));
        idle(30);

        // Address aliasing and ignored byte offset.
        send(1'b1, 32'h0000_0000, 512'd1, 1'b0);
        idle(6);
        send(1'b0, 32'h0000_4000, '0, 1'b1);
        send(1'b0, 32'h0000_003F, '0, 1'b0);
        idle(12);

        // Push into an idle endpoint with one queued entry (push and pop same edge).
        d1 = rnd512();
        send(1'b1, 32'h0000_00C0, d1, 1'b1);
        send(1'b0, 32'h0000_00C0, '0, 1'b0);
        idle(12);

        // Reset during ACCESS with two requests queued behind it.
        d1 = rnd512();
        d2 = rnd512();
        send(1'b1, 32'h0000_0080, d1, 1'b0);
        idle(6);
        send(1'b1, 32'h0000_0080, d2, 1'b1);
        send(1'b0, 32'h0000_0080, '0, 1'b0);
        send(1'b0, 32'h0000_0040, '0, 1'b1);
        do_reset();
        idle(12);
        send(1'b0, 32'h0000_0080, '0, 1'b1);
        idle(6);
        chk("persist_after_reset", mem_m[2], d1);

        // Route tag on the deeper network configuration.
        dr = rnd512();
        route_test(1'b1, 4'b1011, dr, '0);
        route_test(1'b0, 4'b0110, '0, dr);

        // Randomized mix of reads and writes with aliasing addresses and gaps.
        for (int k = 0; k < 60; k++) begin
            int ix;
            bit w;
            logic [31:0] a;
            if (k < 8) begin
                ix = k;
                w = 1'b1;
            end else begin
                ix = int'($urandom_range(7));
                w = bit'($urandom_range(1));
            end
            if (!w && !wr_set[ix]) w = 1'b1;
            a = ($urandom << 14) | (32'(ix) << 6) | 32'($urandom_range(63));
            if (w) wr_set[ix] = 1'b1;
            send(w, a, rnd512(), 1'($urandom_range(1)));
            if ($urandom_range(3) != 0) idle(int'($urandom_range(3)));
        end
        idle(40);
        chk("drained", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_memory_endpoint.md
Name: noc_memory_endpoint

Overview:
- Memory-side responder terminating the N3XT NOC.
- Accepts C2M requests (data, address, write flag, route tag) from the root switch into a small request FIFO.
- Services requests one at a time against an on-chip memory array with fixed access latency.
- Emits M2C responses whose AccessComplete vector carries the route tag that the switch decoders consume, low bits first, on the way back down.

Parameters:
- BIT_WIDTH, 512: data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32: byte address width.
- RADIX, 2: switch radix; sets ROUTE_W.
- NETWORK_DEPTH, 1: number of switch levels; ROUTE_W = $clog2(RADIX)*NETWORK_DEPTH.
- MEM_DEPTH, 256: number of words in the array; power of 2.
- MEM_LATENCY, 2: cycles spent in ACCESS; must be 1 or more.
- FIFO_DEPTH, 4: request FIFO entries; power of 2, 2 or more.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en_C2M_IN  in  1  request valid
- We_C2M_IN  in  1  1 = write, 0 = read
- Data_C2M_IN  in  BIT_WIDTH  write data
- Addr_C2M_IN  in  ADDR_WIDTH  byte address
- Route_C2M_IN  in  ROUTE_W  return-path tag accumulated by the switches
- ready_C2M_OUT  out  1  request FIFO not full
- en_M2C_OUT  out  1  response valid, single-cycle pulse
- Data_M2C_OUT  out  BIT_WIDTH  read data; zero for write acks
- AccessComplete_M2C_OUT  out  ROUTE_W+1  {route tag, 1'b1} when en_M2C_OUT is high, else zero

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; FSM to IDLE.
  - ready_C2M_OUT = 1; en_M2C_OUT = 0; Data_M2C_OUT = 0; AccessComplete_M2C_OUT = 0.
  - Memory contents are not reset and are undefined until written.
- Accept: handshake fires when en_C2M_IN && ready_C2M_OUT.
  - The entry {We, Data, Addr, Route} is pushed at that clock edge.
  - When FIFO is full, ready_C2M_OUT = 0 and en_C2M_IN is ignored; the request is not stored. Upstream must hold the request.
  - ready_C2M_OUT is registered: it deasserts in the cycle after the push that fills the FIFO.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
- Word index = Addr[ADDR_LSB +: $clog2(MEM_DEPTH)], where ADDR_LSB = $clog2(BIT_WIDTH/8).
  - Lower byte-offset bits are ignored; upper bits alias (wrap).
- FSM:
  - IDLE: if FIFO is not empty, pop the head into the working register, load counter = MEM_LATENCY-1, and go to ACCESS. Otherwise stay.
  - ACCESS: if counter == 0, perform the access at that edge and go to RESPOND. A write stores Data; a read captures mem[idx] into the response register. Otherwise decrement the counter.
  - RESPOND: drive en_M2C_OUT = 1, Data_M2C_OUT = read data (0 for a write), and AccessComplete_M2C_OUT = {Route, 1'b1}. Return to IDLE.
  - All response outputs are registered and return to 0 in the cycle after RESPOND.
- Latency: a request accepted in cycle T into an empty, idle endpoint responds in cycle T+2+MEM_LATENCY. With default parameters that is T+4.
- Throughput: one response per MEM_LATENCY+2 cycles.
- Ordering is strict FIFO. Read-after-write to the same index returns the new data.
- M2C has no backpressure; the response is valid for exactly one cycle.
- Reset mid-operation:
  - In-flight and queued requests are dropped; no response is emitted for them.
  - Memory writes already committed persist.

Decomposition:
- Package noc_pkg:
  - ROUTE_W function/localparam.
  - ADDR_LSB helper.
  - typedef endpoint_state_t {IDLE, ACCESS, RESPOND}.
  - Packed request struct typedef {we, data, addr, route}. This package is shared with the switch side.
- Sub-module noc_req_fifo:
  - Parameterised width/depth synchronous FIFO.
  - Async active-high reset.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers carry an extra wrap bit.
- Memory array and FSM stay in the top module.

Test Plan:
- Write then read: write A=0x40, data=0xAA..AA, route=1. Expect ack at T+4 with AccessComplete=2'b11 and Data=0. Then read A=0x40, route=0. Expect Data=0xAA..AA and AccessComplete=2'b01 four cycles after acceptance.
- Backpressure: hold en_C2M_IN for 6 back-to-back reads. Expect ready_C2M_OUT low after 4 stored entries plus one popped. Expect exactly 6 responses in order, spaced 4 cycles apart, with no lost request.
- Address alias: write A=0x0, data=1; read A=0x4000 (MEM_DEPTH*64). Expect Data=1. Read A=0x3F. Expect Data=1, showing byte offset ignored.
- Route tag: RADIX=4, NETWORK_DEPTH=2, route=4'b1011. Expect AccessComplete_M2C_OUT=5'b10111.
- Reset mid-access: assert rst during ACCESS with 2 entries queued. Expect outputs 0 immediately, ready=1, and no responses afterwards. A following read of the previously written address returns the data written before reset.
- Simultaneous push/pop: FIFO holds 1 entry and FSM is in IDLE while a new request arrives. Expect the count to stay at 1 and both responses to appear in order.
